// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the ID-stage hazard/flush sequencer: control-flag bit
// positions, next-PC select codes and the sequencer FSM states.
package pipe_ctrl_pkg;

    localparam int FLAG_W       = 10;
    localparam int FLG_REGDST   = 9;
    localparam int FLG_JUMP     = 8;
    localparam int FLG_BRANCH   = 7;
    localparam int FLG_MEMREAD  = 6;
    localparam int FLG_MEMTOREG = 5;
    localparam int FLG_ALUOP0   = 4;
    localparam int FLG_ALUOP1   = 3;
    localparam int FLG_MEMWRITE = 2;
    localparam int FLG_ALUSRC   = 1;
    localparam int FLG_REGWRITE = 0;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b01;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b10;

    localparam logic [FLAG_W-1:0] FLAG_BUBBLE = 10'b0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FREEZE = 2'd2
    } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    output logic [PERF_W-1:0] count
);

    logic [PERF_W-1:0] count_q;
    logic [PERF_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {PERF_W{1'b1}})) begin
            count_d = count_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ID-stage sequencer: load-use bubbles, jump/branch squash and memory-busy freeze,
// with saturating stall and flush event counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int PERF_W            = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [9:0]        id_flag,
    input  logic              ex_memread,
    input  logic [4:0]        ex_rt,
    input  logic              ex_br_taken,
    input  logic              dmem_busy,
    output logic              pc_we,
    output logic [1:0]        pc_sel,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic [9:0]        idex_flag,
    output logic              exmem_we,
    output logic              memwb_we,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    localparam logic [2:0] REM_INIT = 3'(LOAD_STALL_CYCLES - 1);

    hz_state_e  state_q, state_d;
    hz_state_e  ret_q, ret_d;
    hz_state_e  mode;
    logic [2:0] rem_q, rem_d;
    logic       load_use;
    logic       stall_inc;
    logic       flush_inc;

    // While frozen, the pipe resumes as whichever state it was in before the freeze.
    assign mode = (state_q == ST_FREEZE) ? ret_q : state_q;

    // A store or register-form instruction also reads rt, so it waits on a load to rt.
    assign load_use = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) ||
                       ((ex_rt == id_rt) && (!id_flag[FLG_ALUSRC] || id_flag[FLG_MEMWRITE])));

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        rem_d      = rem_q;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        pc_we      = 1'b1;
        pc_sel     = PC_SEL_SEQ;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        idex_flag  = id_flag;
        exmem_we   = 1'b1;
        memwb_we   = 1'b1;

        if (dmem_busy) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            exmem_we = 1'b0;
            memwb_we = 1'b0;
            state_d  = ST_FREEZE;
            ret_d    = mode;
        end else if (ex_br_taken) begin
            pc_sel     = PC_SEL_BRANCH;
            ifid_flush = 1'b1;
            idex_flag  = FLAG_BUBBLE;
            flush_inc  = 1'b1;
            state_d    = ST_RUN;
            rem_d      = 3'd0;
        end else if (mode == ST_STALL) begin
            pc_we     = 1'b0;
            ifid_we   = 1'b0;
            idex_flag = FLAG_BUBBLE;
            stall_inc = 1'b1;
            rem_d     = rem_q - 3'd1;
            state_d   = (rem_q == 3'd1) ? ST_RUN : ST_STALL;
        end else if (load_use) begin
            pc_we     = 1'b0;
            ifid_we   = 1'b0;
            idex_flag = FLAG_BUBBLE;
            stall_inc = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_d = ST_STALL;
                rem_d   = REM_INIT;
            end else begin
                state_d = ST_RUN;
            end
        end else if (id_flag[FLG_JUMP]) begin
            pc_sel     = PC_SEL_JUMP;
            ifid_flush = 1'b1;
            flush_inc  = 1'b1;
            state_d    = ST_RUN;
        end else begin
            state_d = ST_RUN;
        end

        // Outputs follow the reset immediately rather than waiting for a clock edge.
        if (!rst_n) begin
            pc_we      = 1'b0;
            pc_sel     = PC_SEL_SEQ;
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
            idex_flag  = FLAG_BUBBLE;
            exmem_we   = 1'b0;
            memwb_we   = 1'b0;
            stall_inc  = 1'b0;
            flush_inc  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            ret_q   <= ST_RUN;
            rem_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            rem_q   <= rem_d;
        end
    end

    sat_counter #(.PERF_W(PERF_W)) u_stall_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.PERF_W(PERF_W)) u_flush_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Three sequencer instances (1/2/3 bubbles, one with 4-bit counters) share stimulus
// and are compared each cycle against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic [9:0] id_flag;
    logic       ex_memread, ex_br_taken, dmem_busy;

    logic        pc_we0, ifid_we0, ifid_flush0, exmem_we0, memwb_we0;
    logic [1:0]  pc_sel0;
    logic [9:0]  idex_flag0;
    logic [15:0] stall_cnt0, flush_cnt0;
    logic        pc_we1, ifid_we1, ifid_flush1, exmem_we1, memwb_we1;
    logic [1:0]  pc_sel1;
    logic [9:0]  idex_flag1;
    logic [15:0] stall_cnt1, flush_cnt1;
    logic        pc_we2, ifid_we2, ifid_flush2, exmem_we2, memwb_we2;
    logic [1:0]  pc_sel2;
    logic [9:0]  idex_flag2;
    logic [3:0]  stall_cnt2, flush_cnt2;

    logic [16:0] ctrl_obs  [3];
    logic [15:0] stall_obs [3];
    logic [15:0] flush_obs [3];

    int n_tests;
    int n_fail;
    int lsc  [3];
    int cmax [3];
    int rem  [3];
    int stl  [3];
    int fls  [3];

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .PERF_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_flag(id_flag),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_br_taken(ex_br_taken), .dmem_busy(dmem_busy),
        .pc_we(pc_we0), .pc_sel(pc_sel0), .ifid_we(ifid_we0), .ifid_flush(ifid_flush0),
        .idex_flag(idex_flag0), .exmem_we(exmem_we0), .memwb_we(memwb_we0),
        .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
    );

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(2), .PERF_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_flag(id_flag),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_br_taken(ex_br_taken), .dmem_busy(dmem_busy),
        .pc_we(pc_we1), .pc_sel(pc_sel1), .ifid_we(ifid_we1), .ifid_flush(ifid_flush1),
        .idex_flag(idex_flag1), .exmem_we(exmem_we1), .memwb_we(memwb_we1),
        .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
    );

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .PERF_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_flag(id_flag),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_br_taken(ex_br_taken), .dmem_busy(dmem_busy),
        .pc_we(pc_we2), .pc_sel(pc_sel2), .ifid_we(ifid_we2), .ifid_flush(ifid_flush2),
        .idex_flag(idex_flag2), .exmem_we(exmem_we2), .memwb_we(memwb_we2),
        .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    assign ctrl_obs[0]  = {pc_we0, pc_sel0, ifid_we0, ifid_flush0, idex_flag0, exmem_we0, memwb_we0};
    assign ctrl_obs[1]  = {pc_we1, pc_sel1, ifid_we1, ifid_flush1, idex_flag1, exmem_we1, memwb_we1};
    assign ctrl_obs[2]  = {pc_we2, pc_sel2, ifid_we2, ifid_flush2, idex_flag2, exmem_we2, memwb_we2};
    assign stall_obs[0] = stall_cnt0;
    assign stall_obs[1] = stall_cnt1;
    assign stall_obs[2] = {12'h000, stall_cnt2};
    assign flush_obs[0] = flush_cnt0;
    assign flush_obs[1] = flush_cnt1;
    assign flush_obs[2] = {12'h000, flush_cnt2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] timeout");
    end

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic busy, input logic br,
                                 input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [9:0] flag);
        @(posedge clk);
        #1;
        rst_n       = rst;
        dmem_busy   = busy;
        ex_br_taken = br;
        ex_memread  = mr;
        ex_rt       = ert;
        id_rs       = rs;
        id_rt       = rt;
        id_flag     = flag;
    endtask

    // Expected outputs come straight from the priority rules; the model then
    // advances its bubble budget and counters as the coming clock edge would.
    task automatic checkOutput(input string tag);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            logic [16:0] e;
            bit          sinc;
            bit          finc;
            bit          lu;
            int          nrem;
            sinc = 1'b0;
            finc = 1'b0;
            if (!rst_n) begin
                rem[i] = 0;
                stl[i] = 0;
                fls[i] = 0;
            end
            nrem = rem[i];
            lu = ex_memread && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || ((ex_rt == id_rt) && (!id_flag[1] || id_flag[2])));
            if (!rst_n) begin
                e = {1'b0, 2'b00, 1'b0, 1'b1, 10'h000, 1'b0, 1'b0};
            end else if (dmem_busy) begin
                e = {1'b0, 2'b00, 1'b0, 1'b0, id_flag, 1'b0, 1'b0};
            end else if (ex_br_taken) begin
                e = {1'b1, 2'b10, 1'b1, 1'b1, 10'h000, 1'b1, 1'b1};
                finc = 1'b1;
                nrem = 0;
            end else if (rem[i] > 0) begin
                e = {1'b0, 2'b00, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1};
                sinc = 1'b1;
                nrem = rem[i] - 1;
            end else if (lu) begin
                e = {1'b0, 2'b00, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1};
                sinc = 1'b1;
                nrem = lsc[i] - 1;
            end else if (id_flag[8]) begin
                e = {1'b1, 2'b01, 1'b1, 1'b1, id_flag, 1'b1, 1'b1};
                finc = 1'b1;
            end else begin
                e = {1'b1, 2'b00, 1'b1, 1'b0, id_flag, 1'b1, 1'b1};
            end
            compare($sformatf("%s.u%0d.ctrl", tag, i), 32'(ctrl_obs[i]), 32'(e));
            compare($sformatf("%s.u%0d.stall_cnt", tag, i), 32'(stall_obs[i]), 32'(stl[i]));
            compare($sformatf("%s.u%0d.flush_cnt", tag, i), 32'(flush_obs[i]), 32'(fls[i]));
            if (rst_n) begin
                rem[i] = nrem;
                if (sinc && stl[i] < cmax[i]) stl[i]++;
                if (finc && fls[i] < cmax[i]) fls[i]++;
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        lsc  = '{1, 2, 3};
        cmax = '{65535, 65535, 15};
        rem  = '{0, 0, 0};
        stl  = '{0, 0, 0};
        fls  = '{0, 0, 0};
        rst_n = 1'b0; dmem_busy = 1'b0; ex_br_taken = 1'b0; ex_memread = 1'b0;
        ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_flag = 10'h000;

        applyStimulus(1'b0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 10'h000); checkOutput("reset");
        applyStimulus(1'b1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 10'h000); checkOutput("idle");
        applyStimulus(1'b1, 0, 0, 0, 5'd0, 5'd3, 5'd4, 10'h261); checkOutput("normal");

        applyStimulus(1'b1, 0, 0, 1, 5'd8, 5'd8, 5'd0, 10'h201); checkOutput("lu_rs");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 10'h201); checkOutput("lu_drain");
        end
        compare("lu_rs.stall_cnt_u0", 32'(stall_obs[0]), 32'd1);

        applyStimulus(1'b1, 0, 0, 1, 5'd8, 5'd1, 5'd8, 10'h003); checkOutput("lu_rt_alusrc");
        applyStimulus(1'b1, 0, 0, 1, 5'd8, 5'd1, 5'd8, 10'h006); checkOutput("lu_rt_store");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 10'h000); checkOutput("store_drain");
        end
        applyStimulus(1'b1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 10'h201); checkOutput("lu_r0");

        applyStimulus(1'b1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 10'h100); checkOutput("br_jump");
        applyStimulus(1'b1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 10'h100); checkOutput("jump");
        applyStimulus(1'b1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 10'h000); checkOutput("post_jump");
        compare("br_jump.flush_cnt_u0", 32'(flush_obs[0]), 32'd2);

        // Freeze in the middle of the two-bubble stall
        applyStimulus(1'b0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 10'h000); checkOutput("rst_pre_freeze");
        applyStimulus(1'b1, 0, 0, 1, 5'd9, 5'd9, 5'd0, 10'h001); checkOutput("freeze_lu");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 10'h021); checkOutput("freeze_busy");
        end
        applyStimulus(1'b1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 10'h021); checkOutput("freeze_resume");
        applyStimulus(1'b1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 10'h021); checkOutput("freeze_run");
        compare("freeze.stall_cnt_u1", 32'(stall_obs[1]), 32'd2);
        compare("freeze.run_ctrl_u1", 32'(ctrl_obs[1]), 32'({1'b1, 2'b00, 1'b1, 1'b0, 10'h021, 1'b1, 1'b1}));

        // Reset asserted during the second cycle of a three-bubble stall
        applyStimulus(1'b1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 10'h001); checkOutput("rst_stall_lu");
        applyStimulus(1'b1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 10'h001); checkOutput("rst_stall_c1");
        applyStimulus(1'b0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 10'h001); checkOutput("rst_stall_c2");
        applyStimulus(1'b1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 10'h001); checkOutput("rst_stall_rel");
        compare("rst_stall.stall_cnt_u2", 32'(stall_obs[2]), 32'd0);
        compare("rst_stall.run_ctrl_u2", 32'(ctrl_obs[2]), 32'({1'b1, 2'b00, 1'b1, 1'b0, 10'h001, 1'b1, 1'b1}));

        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'b1, 0, 0, 1, 5'd7, 5'd7, 5'd0, 10'h001); checkOutput("saturate");
        end
        compare("saturate.stall_cnt_u2", 32'(stall_obs[2]), 32'h000F);
        applyStimulus(1'b1, 0, 0, 1, 5'd7, 5'd7, 5'd0, 10'h001); checkOutput("saturate_more");
        applyStimulus(1'b1, 0, 0, 1, 5'd7, 5'd7, 5'd0, 10'h001); checkOutput("saturate_more");
        compare("saturate_hold.stall_cnt_u2", 32'(stall_obs[2]), 32'h000F);

        for (int k = 0; k < 400; k++) begin
            logic [9:0] flag;
            flag    = 10'($urandom);
            flag[8] = ($urandom_range(0, 3) == 0);
            applyStimulus(1'b1, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 4)),
                          5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)), flag);
            checkOutput("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
